sprite_addr_gen: RTL and testbench

- Multi-sprite successor to the single-sprite combinational pattern address calculator.
- Serves NUM_SPRITES sprite slots in parallel and replaces the per-pixel modulo/multiply with per-sprite running tile counters.
- Selects the highest-priority hit (lowest slot index) and presents one registered sprite-RAM address per pixel with fixed 2-cycle latency.
- Sits between the VGA timing counter and the sprite pattern ROM/RAM in the Avalon VGA peripheral.

---
 rtl/sprite_addr_gen.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sprite_addr_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// sprite_addr_gen
//
// Multi-sprite pattern address generator for the Avalon VGA peripheral. It sits
// between the VGA timing counter and the sprite pattern ROM/RAM. NUM_SPRITES
// slots are evaluated in parallel. The lowest-index visible slot that covers
// the current pixel wins, and its pattern address comes out two clock cycles
// after the pixel was presented.
//
// Tile addressing has no per-pixel modulo or multiply. Each slot keeps running
// counters instead:
//   cx       column inside the tile, wraps at res_h
//   ry       row inside the tile, wraps at res_v
//   row_base ry*res_h, built up by repeated addition
//
// Sprite and pattern descriptors are double-buffered. The live inputs are
// copied into shadow registers on frame_sync, and all logic runs from the
// shadows, so the host can rewrite descriptors mid-frame without tearing.
//
// Optional feature (define SPRITE_COLLISION_EN):
//   collision      1 when two or more enabled slots hit the pixel (aligned
//                  with out_en)
//   collision_seen sticky; set by any collision, cleared by frame_sync
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   pattern_info   per slot s, [80s+79:80s] =
//                  {append, res_h, res_v, act_h, act_v}, 16 bits each
//   sprite_info    per slot s, [32s+31:32s] =
//                  {visible, flip, x_pos[9:0], y_pos[9:0], shift[9:0]}
//   frame_sync     vblank pulse that loads the shadow registers
//   pix_en         pixel strobe; hcount/vcount are valid while it is high
//   hcount/vcount  current pixel column/row
//   addr_out       pattern address of the winning slot (0 when no hit)
//   hit            a visible sprite covers the pixel
//   sprite_id      index of the winning slot (0 when no hit)
//   out_en         pix_en delayed two cycles; qualifies the three outputs above
// -----------------------------------------------------------------------------
module sprite_addr_gen #(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 16,
  parameter int COORD_W     = 10,
  localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SPRITES*80-1:0] pattern_info,
  input  logic [NUM_SPRITES*32-1:0] sprite_info,
  input  logic                      frame_sync,
  input  logic                      pix_en,
  input  logic [COORD_W-1:0]        hcount,
  input  logic [COORD_W-1:0]        vcount,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      hit,
  output logic [ID_W-1:0]           sprite_id,
  output logic                      out_en
`ifdef SPRITE_COLLISION_EN
  ,
  output logic                      collision,
  output logic                      collision_seen
`endif
);

  localparam int CW1 = COORD_W + 1;

  typedef struct packed {
    logic [15:0] append;
    logic [15:0] res_h;
    logic [15:0] res_v;
    logic [15:0] act_h;
    logic [15:0] act_v;
  } pattern_t;

  typedef struct packed {
    logic       visible;
    logic       flip;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [9:0] shift;
  } sprite_t;

  // ---------------------------------------------------------------------------
  // Shadow descriptors
  // ---------------------------------------------------------------------------
  pattern_t pat_q [NUM_SPRITES];
  sprite_t  spr_q [NUM_SPRITES];

  // NOTE: the shadow arrays are reset on purpose. Clearing visible is what
  // keeps every slot dark from reset until the first frame_sync, so this
  // storage must not be left uninitialised the way a plain RAM would be.
  // NOTE: every clocked block uses non-blocking (<=) assignments, so all
  // registers sample their inputs at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        pat_q[s] <= '0;
        spr_q[s] <= '0;
      end
    end else if (frame_sync) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        pat_q[s] <= pattern_t'(pattern_info[80*s +: 80]);
        spr_q[s] <= sprite_t'(sprite_info[32*s +: 32]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot span tests, counters and address
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] x_pos_c   [NUM_SPRITES];
  logic [COORD_W-1:0] y_pos_c   [NUM_SPRITES];
  logic [CW1-1:0]     x_end     [NUM_SPRITES];
  logic [CW1-1:0]     y_end     [NUM_SPRITES];
  logic [16:0]        ry_inc    [NUM_SPRITES];
  logic [16:0]        cx_inc    [NUM_SPRITES];
  logic [15:0]        ry_q      [NUM_SPRITES];
  logic [15:0]        ry_nx     [NUM_SPRITES];
  logic [15:0]        cx_q      [NUM_SPRITES];
  logic [15:0]        cx_nx     [NUM_SPRITES];
  logic [15:0]        x_term    [NUM_SPRITES];
  logic [ADDR_W-1:0]  rb_q      [NUM_SPRITES];
  logic [ADDR_W-1:0]  rb_nx     [NUM_SPRITES];
  logic [ADDR_W-1:0]  slot_addr [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] h_in;
  logic [NUM_SPRITES-1:0] v_in;
  logic [NUM_SPRITES-1:0] slot_en;
  logic [NUM_SPRITES-1:0] slot_hit;

  // NOTE: every variable of this block gets a value on every pass, either
  // directly or as a hold default before the conditional updates. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    for (int s = 0; s < NUM_SPRITES; s++) begin
      slot_en[s] = spr_q[s].visible && (pat_q[s].res_h != '0) && (pat_q[s].res_v != '0);

      // Span ends are one bit wider than the coordinates, so a sprite that
      // runs off the right or bottom edge is clipped instead of wrapping
      // around to 0.
      x_pos_c[s] = COORD_W'(spr_q[s].x_pos);
      y_pos_c[s] = COORD_W'(spr_q[s].y_pos);
      x_end[s]   = {1'b0, x_pos_c[s]} + CW1'(pat_q[s].act_h);
      y_end[s]   = {1'b0, y_pos_c[s]} + CW1'(pat_q[s].act_v);
      h_in[s]    = (hcount >= x_pos_c[s]) && ({1'b0, hcount} < x_end[s]);
      v_in[s]    = (vcount >= y_pos_c[s]) && ({1'b0, vcount} < y_end[s]);

      // Row state advances once per line, on the hcount==0 pixel. That
      // pixel already sees the new value.
      ry_inc[s] = {1'b0, ry_q[s]} + 17'd1;
      ry_nx[s]  = ry_q[s];
      rb_nx[s]  = rb_q[s];
      if (pix_en && (hcount == '0)) begin
        if (vcount == y_pos_c[s]) begin
          ry_nx[s] = '0;
          rb_nx[s] = '0;
        end else if (v_in[s]) begin
          if (ry_inc[s] >= {1'b0, pat_q[s].res_v}) begin
            ry_nx[s] = '0;
            rb_nx[s] = '0;
          end else begin
            ry_nx[s] = ry_inc[s][15:0];
            rb_nx[s] = rb_q[s] + ADDR_W'(pat_q[s].res_h);
          end
        end
      end

      // Column state loads the start offset at x_pos and steps on each later
      // in-span pixel. Every pixel uses its own updated column.
      cx_inc[s] = {1'b0, cx_q[s]} + 17'd1;
      cx_nx[s]  = cx_q[s];
      if (pix_en) begin
        if (hcount == x_pos_c[s]) begin
          cx_nx[s] = (16'(spr_q[s].shift) < pat_q[s].res_h) ? 16'(spr_q[s].shift) : '0;
        end else if (h_in[s]) begin
          cx_nx[s] = (cx_inc[s] >= {1'b0, pat_q[s].res_h}) ? '0 : cx_inc[s][15:0];
        end
      end

      x_term[s]    = spr_q[s].flip ? (pat_q[s].res_h - 16'd1 - cx_nx[s]) : cx_nx[s];
      slot_addr[s] = ADDR_W'(pat_q[s].append) + rb_nx[s] + ADDR_W'(x_term[s]);
      slot_hit[s]  = pix_en && slot_en[s] && h_in[s] && v_in[s];
    end
  end

  // The counters hold by themselves whenever pix_en is low, because the next
  // values above only change on a strobed pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        cx_q[s] <= '0;
        ry_q[s] <= '0;
        rb_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        cx_q[s] <= cx_nx[s];
        ry_q[s] <= ry_nx[s];
        rb_q[s] <= rb_nx[s];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-slot hit and address
  // ---------------------------------------------------------------------------
  logic                   s1_en;
  logic [NUM_SPRITES-1:0] s1_hit;
  logic [ADDR_W-1:0]      s1_addr [NUM_SPRITES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_en  <= 1'b0;
      s1_hit <= '0;
      for (int s = 0; s < NUM_SPRITES; s++) s1_addr[s] <= '0;
    end else begin
      s1_en  <= pix_en;
      s1_hit <= slot_hit;
      for (int s = 0; s < NUM_SPRITES; s++) s1_addr[s] <= slot_addr[s];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: priority select, lowest index wins
  // ---------------------------------------------------------------------------
  logic              win_hit;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_addr;

  // The scan runs from the highest index down, so the last match to write
  // the result is the lowest index.
  always_comb begin
    win_hit  = 1'b0;
    win_id   = '0;
    win_addr = '0;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (s1_hit[s]) begin
        win_hit  = 1'b1;
        win_id   = ID_W'(s);
        win_addr = s1_addr[s];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_en    <= 1'b0;
      hit       <= 1'b0;
      sprite_id <= '0;
      addr_out  <= '0;
    end else begin
      out_en    <= s1_en;
      hit       <= win_hit;
      sprite_id <= win_id;
      addr_out  <= win_addr;
    end
  end

`ifdef SPRITE_COLLISION_EN
  // Clearing the lowest set bit leaves something nonzero only if at least
  // two slots hit.
  logic multi_hit;
  assign multi_hit = (s1_hit & (s1_hit - 1'b1)) != '0;

  // frame_sync only arrives during vblank, when nothing can collide, so its
  // clear takes precedence over a set in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision      <= 1'b0;
      collision_seen <= 1'b0;
    end else begin
      collision <= multi_hit;
      if (frame_sync)     collision_seen <= 1'b0;
      else if (multi_hit) collision_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_sprite_addr_gen
//
// Directed bench for sprite_addr_gen. It scans a small 48x48 raster. Each line
// is followed by two idle cycles so the counters are seen to hold while pix_en
// is low. Every qualified output is stored against the pixel that produced it,
// and the stored values are then compared with hand-computed addresses.
// -----------------------------------------------------------------------------
module tb_sprite_addr_gen;

  localparam int H_TOT = 48;
  localparam int V_TOT = 48;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [319:0] pattern_info;
  logic [127:0] sprite_info;
  logic         frame_sync;
  logic         pix_en;
  logic [9:0]   hcount;
  logic [9:0]   vcount;
  logic [15:0]  addr_out;
  logic         hit;
  logic [1:0]   sprite_id;
  logic         out_en;
`ifdef SPRITE_COLLISION_EN
  logic         collision;
  logic         collision_seen;
`endif

  sprite_addr_gen #(.NUM_SPRITES(4), .ADDR_W(16), .COORD_W(10)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pattern_info  (pattern_info),
    .sprite_info   (sprite_info),
    .frame_sync    (frame_sync),
    .pix_en        (pix_en),
    .hcount        (hcount),
    .vcount        (vcount),
    .addr_out      (addr_out),
    .hit           (hit),
    .sprite_id     (sprite_id),
    .out_en        (out_en)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision     (collision),
    .collision_seen(collision_seen)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output capture: a two-deep pipe of the pixels presented, kept in step
  // with the DUT outputs
  // ---------------------------------------------------------------------------
  logic       d1_en, d2_en;
  logic [9:0] d1_h, d1_v, d2_h, d2_v;
  logic [15:0] cap_addr [V_TOT][H_TOT];
  logic        cap_hit  [V_TOT][H_TOT];
  logic [1:0]  cap_id   [V_TOT][H_TOT];
`ifdef SPRITE_COLLISION_EN
  logic        cap_col  [V_TOT][H_TOT];
`endif
  int frame_hits = 0;
  int align_err  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_en <= 1'b0; d2_en <= 1'b0;
      d1_h <= '0; d1_v <= '0; d2_h <= '0; d2_v <= '0;
    end else begin
      d1_en <= pix_en; d1_h <= hcount; d1_v <= vcount;
      d2_en <= d1_en;  d2_h <= d1_h;   d2_v <= d1_v;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_en !== d2_en) align_err++;
      if (d2_en) begin
        cap_addr[d2_v][d2_h] = addr_out;
        cap_hit[d2_v][d2_h]  = hit;
        cap_id[d2_v][d2_h]   = sprite_id;
`ifdef SPRITE_COLLISION_EN
        cap_col[d2_v][d2_h]  = collision;
`endif
        if (hit === 1'b1) frame_hits++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [79:0] mk_pat(input logic [15:0] app, rh, rv, ah, av);
    return {app, rh, rv, ah, av};
  endfunction

  function automatic logic [31:0] mk_spr(input logic vis, flp, input logic [9:0] x, y, sh);
    return {vis, flp, x, y, sh};
  endfunction

  task automatic set_slot(input int s, input logic [79:0] p, input logic [31:0] sp);
    pattern_info[80*s +: 80] = p;
    sprite_info[32*s +: 32]  = sp;
  endtask

  task automatic clear_slots();
    pattern_info = '0;
    sprite_info  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  // Scans one frame. It can pulse frame_sync first, and it can rewrite one
  // slot's sprite_info at the start of line mid_line (use -1 for no rewrite).
  task automatic scan_frame(input bit do_sync, input int mid_line, input int mid_slot,
                            input logic [31:0] mid_spr);
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++) begin
        cap_addr[v][h] = 'x;
        cap_hit[v][h]  = 1'bx;
        cap_id[v][h]   = 'x;
`ifdef SPRITE_COLLISION_EN
        cap_col[v][h]  = 1'bx;
`endif
      end
    frame_hits = 0;
    if (do_sync) sync();
    for (int v = 0; v < V_TOT; v++) begin
      if (v == mid_line) sprite_info[32*mid_slot +: 32] = mid_spr;
      for (int h = 0; h < H_TOT; h++) begin
        pix_en = 1'b1; hcount = 10'(h); vcount = 10'(v);
        tick();
      end
      pix_en = 1'b0;
      tick();
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic check_px(input string tag, input int h, input int v, input logic eh,
                          input logic [1:0] eid, input logic [15:0] ea);
    check({tag, ".hit"},  {31'b0, cap_hit[v][h]},  {31'b0, eh});
    check({tag, ".id"},   {30'b0, cap_id[v][h]},   {30'b0, eid});
    check({tag, ".addr"}, {16'b0, cap_addr[v][h]}, {16'b0, ea});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0; frame_sync = 1'b0; pix_en = 1'b0;
    hcount = '0; vcount = '0;
    clear_slots();
    repeat (3) tick();

    // Reset state
    check("rst.out_en", {31'b0, out_en}, 32'd0);
    check("rst.hit",    {31'b0, hit},    32'd0);
    check("rst.id",     {30'b0, sprite_id}, 32'd0);
    check("rst.addr",   {16'b0, addr_out},  32'd0);
    reset_n = 1'b1;
    tick();

    // Basic sprite: 16x16 tile at (10,5), append 0x100. The descriptors are
    // applied but not yet synced, so nothing may show.
    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(1, 0, 10, 5, 0));
    scan_frame(0, -1, 0, '0);
    check("nosync.hits", frame_hits, 0);

    scan_frame(1, -1, 0, '0);
    check_px("basic(10,5)",  10, 5,  1, 0, 16'h0100);
    check_px("basic(25,20)", 25, 20, 1, 0, 16'h01FF);
    check_px("basic(26,5)",  26, 5,  0, 0, 16'h0000);
    check_px("basic(10,21)", 10, 21, 0, 0, 16'h0000);
    check("basic.hits", frame_hits, 256);

    // Flip
    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(1, 1, 10, 5, 0));
    scan_frame(1, -1, 0, '0);
    check_px("flip(10,5)",  10, 5,  1, 0, 16'h010F);
    check_px("flip(25,5)",  25, 5,  1, 0, 16'h0100);
    check_px("flip(25,20)", 25, 20, 1, 0, 16'h01F0);

    // Tiling with shift: 8x4 tile repeated over a 24x12 area, start column 3
    set_slot(0, mk_pat(16'h0100, 8, 4, 24, 12), mk_spr(1, 0, 10, 5, 3));
    scan_frame(1, -1, 0, '0);
    check_px("tile(10,5)",  10, 5,  1, 0, 16'h0103);
    check_px("tile(15,5)",  15, 5,  1, 0, 16'h0100);
    check_px("tile(17,6)",  17, 6,  1, 0, 16'h010A);
    check_px("tile(10,9)",  10, 9,  1, 0, 16'h0103);
    check_px("tile(33,16)", 33, 16, 1, 0, 16'h011A);
    check_px("tile(34,16)", 34, 16, 0, 0, 16'h0000);
    check("tile.hits", frame_hits, 288);

    // Priority: slots 0 and 2 overlap
    clear_slots();
    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(1, 0, 36, 36, 0));
    set_slot(2, mk_pat(16'h2000, 8, 8, 8, 8),     mk_spr(1, 0, 40, 40, 0));
    scan_frame(1, -1, 0, '0);
    check_px("prio(40,40)", 40, 40, 1, 0, 16'h0144);
    check_px("prio(37,37)", 37, 37, 1, 0, 16'h0111);
    check_px("prio(45,42)", 45, 42, 1, 0, 16'h0169);
`ifdef SPRITE_COLLISION_EN
    check("col(40,40)", {31'b0, cap_col[40][40]}, 32'd1);
    check("col(37,37)", {31'b0, cap_col[37][37]}, 32'd0);
    check("col_seen.set", {31'b0, collision_seen}, 32'd1);
`endif

    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(0, 0, 36, 36, 0));
    sync();
`ifdef SPRITE_COLLISION_EN
    check("col_seen.clr", {31'b0, collision_seen}, 32'd0);
`endif
    scan_frame(0, -1, 0, '0);
    check_px("slot2(40,40)", 40, 40, 1, 2, 16'h2000);
    check_px("slot2(45,42)", 45, 42, 1, 2, 16'h2015);
    check_px("slot2(37,37)", 37, 37, 0, 0, 16'h0000);
`ifdef SPRITE_COLLISION_EN
    check("col_seen.none", {31'b0, collision_seen}, 32'd0);
`endif

    // Degenerate tile: res_h = 0 must never hit
    clear_slots();
    set_slot(1, mk_pat(16'h0300, 0, 16, 16, 16), mk_spr(1, 0, 0, 0, 0));
    scan_frame(1, -1, 0, '0);
    check("res_h0.hits", frame_hits, 0);

    // Shadowing: move x_pos on line 3; no effect until the next frame_sync
    clear_slots();
    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(1, 0, 10, 5, 0));
    scan_frame(1, 3, 0, mk_spr(1, 0, 20, 5, 0));
    check_px("shadowA(10,5)",  10, 5,  1, 0, 16'h0100);
    check_px("shadowA(25,20)", 25, 20, 1, 0, 16'h01FF);
    scan_frame(0, -1, 0, '0);
    check_px("shadowB(10,5)",  10, 5,  1, 0, 16'h0100);
    scan_frame(1, -1, 0, '0);
    check_px("shadowC(20,5)",  20, 5,  1, 0, 16'h0100);
    check_px("shadowC(10,5)",  10, 5,  0, 0, 16'h0000);
    check_px("shadowC(35,20)", 35, 20, 1, 0, 16'h01FF);

    // Reset asserted in the middle of a sprite
    set_slot(0, mk_pat(16'h0100, 16, 16, 16, 16), mk_spr(1, 0, 10, 5, 0));
    sync();
    for (int v = 0; v <= 6; v++)
      for (int h = 0; h < H_TOT; h++) begin
        if (v == 6 && h == 17) break;
        pix_en = 1'b1; hcount = 10'(h); vcount = 10'(v);
        tick();
      end
    check("pre_rst.hit",  {31'b0, hit},      32'd1);
    check("pre_rst.addr", {16'b0, addr_out}, 32'h0115);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst.hit",    {31'b0, hit},       32'd0);
    check("mid_rst.addr",   {16'b0, addr_out},  32'd0);
    check("mid_rst.out_en", {31'b0, out_en},    32'd0);
    check("mid_rst.id",     {30'b0, sprite_id}, 32'd0);
    pix_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    scan_frame(0, -1, 0, '0);
    check("post_rst.hits", frame_hits, 0);
    scan_frame(1, -1, 0, '0);
    check_px("post_rst(10,5)", 10, 5, 1, 0, 16'h0100);

    check("out_en_align", align_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
